// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding,
// register indices seeded after a successful load and the header size.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_SEED_SP,
        ST_SEED_GP,
        ST_DONE,
        ST_ERR
    } bl_state_e;

    localparam logic [4:0] SP_IDX   = 5'd2;
    localparam logic [4:0] GP_IDX   = 5'd3;
    localparam int         HDR_BITS = 64;

    // States in which the loader consumes stream chunks.
    function automatic logic takes_stream(input bl_state_e s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Little-endian shift-in word assembler. Collects OUT_W/IN_W chunks (first
// chunk lands in the LSBs) and flags the cycle in which the final chunk is
// presented, with the complete word available combinationally alongside.
module boot_word_asm #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             chunk_vld,
    input  logic [IN_W-1:0]  chunk,
    output logic             word_vld,
    output logic [OUT_W-1:0] word
);

    localparam int            CHUNKS = OUT_W / IN_W;
    localparam int            CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST   = CW'(CHUNKS - 1);

    logic [OUT_W-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] merged;

    // New chunk enters at the top; older chunks drift toward the LSBs.
    always_comb begin
        // NOTE: every always_comb output gets an unconditional value first,
        // so no path can leave it unassigned and infer a latch.
        merged   = (acc >> IN_W) | (OUT_W'(chunk) << (OUT_W - IN_W));
        word     = merged;
        word_vld = chunk_vld && (cnt == LAST);
    end

    // Shift register and chunk position within the current word.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (chunk_vld) begin
            acc <= merged;
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Program loader: parses a framed image from a chunked byte stream, writes
// the payload to memory, verifies an XOR checksum, seeds sp/gp and then
// releases the core from reset.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              IN_W      = 8,
    parameter int              ADDR_W    = 32,
    parameter int              MEM_WORDS = 5000,
    parameter logic [XLEN-1:0] SP_INIT   = 64'h0000_0000_7fff_fff0,
    parameter logic [XLEN-1:0] GP_INIT   = 64'h0000_0000_1000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    bl_state_e state, next_state;

    logic [31:0]   base, count, idx;
    logic [XLEN-1:0] csum;

    logic                hdr_chunk, dat_chunk, restart_go;
    logic                hdr_vld, dat_vld;
    logic [HDR_BITS-1:0] hdr_word;
    logic [XLEN-1:0]     dat_word;
    logic [31:0]         hdr_base, hdr_count;
    logic                range_bad, last_word;

    logic              s_ready_d, mem_we_d, rf_we_d, core_rst_n_d, done_d, err_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_d, rf_wdata_d;
    logic [4:0]        rf_waddr_d;

    assign hdr_chunk  = s_valid && s_ready && (state == ST_HDR);
    assign dat_chunk  = s_valid && s_ready && ((state == ST_DATA) || (state == ST_CSUM));
    assign restart_go = restart && ((state == ST_DONE) || (state == ST_ERR));

    assign hdr_base  = hdr_word[31:0];
    assign hdr_count = hdr_word[63:32];
    // 33-bit sum so a huge base plus count cannot wrap past the check.
    assign range_bad = ({1'b0, hdr_base} + {1'b0, hdr_count}) > 33'(MEM_WORDS);
    assign last_word = ({1'b0, idx} + 33'd1) == {1'b0, count};

    boot_word_asm #(.IN_W(IN_W), .OUT_W(HDR_BITS)) u_hdr_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (restart_go),
        .chunk_vld (hdr_chunk),
        .chunk     (s_data),
        .word_vld  (hdr_vld),
        .word      (hdr_word)
    );

    // Payload words and the checksum trailer share one assembler.
    boot_word_asm #(.IN_W(IN_W), .OUT_W(XLEN)) u_dat_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (restart_go),
        .chunk_vld (dat_chunk),
        .chunk     (s_data),
        .word_vld  (dat_vld),
        .word      (dat_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_HDR;
        else        state <= next_state;
    end

    // Next-state selection from assembled fields and the restart pulse.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_HDR: begin
                if (hdr_vld) begin
                    if (range_bad)           next_state = ST_ERR;
                    else if (hdr_count == 0) next_state = ST_CSUM;
                    else                     next_state = ST_DATA;
                end
            end
            ST_DATA:    if (dat_vld && last_word) next_state = ST_CSUM;
            ST_CSUM:    if (dat_vld) next_state = (dat_word == csum) ? ST_SEED_SP : ST_ERR;
            ST_SEED_SP: next_state = ST_SEED_GP;
            ST_SEED_GP: next_state = ST_DONE;
            ST_DONE:    if (restart_go) next_state = ST_HDR;
            ST_ERR:     if (restart_go) next_state = ST_HDR;
            default:    next_state = ST_HDR;
        endcase
    end

    // Output values for the coming cycle, decoded from the state being entered.
    always_comb begin
        s_ready_d    = takes_stream(next_state);
        done_d       = (next_state == ST_DONE);
        core_rst_n_d = (next_state == ST_DONE);
        err_d        = (next_state == ST_ERR);
        mem_we_d     = (state == ST_DATA) && dat_vld;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        rf_we_d      = (next_state == ST_SEED_SP) || (next_state == ST_SEED_GP);
        rf_waddr_d   = '0;
        rf_wdata_d   = '0;
        if (mem_we_d) begin
            mem_addr_d  = ADDR_W'(base + idx);
            mem_wdata_d = dat_word;
        end
        if (next_state == ST_SEED_SP) begin
            rf_waddr_d = SP_IDX;
            rf_wdata_d = SP_INIT;
        end else if (next_state == ST_SEED_GP) begin
            rf_waddr_d = GP_IDX;
            rf_wdata_d = GP_INIT;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            s_ready    <= s_ready_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            rf_we      <= rf_we_d;
            rf_waddr   <= rf_waddr_d;
            rf_wdata   <= rf_wdata_d;
            core_rst_n <= core_rst_n_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // Frame bookkeeping: base, word count, write index and running XOR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base  <= '0;
            count <= '0;
            idx   <= '0;
            csum  <= '0;
        end else if (restart_go) begin
            idx  <= '0;
            csum <= '0;
        end else if ((state == ST_HDR) && hdr_vld) begin
            base  <= hdr_base;
            count <= hdr_count;
            idx   <= '0;
            csum  <= '0;
        end else if ((state == ST_DATA) && dat_vld) begin
            idx  <= idx + 32'd1;
            csum <= csum ^ dat_word;
        end
    end

endmodule
